regfile_scoreboard: RTL

Parametrised register file for the custom CPU datapath: DEPTH x DATA_W storage, two asynchronous read ports and one synchronous write port. Adds a write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard so that multi-cycle units can reserve a destination register and stall readers until writeback. It sits between decode (read addresses, reserve) and writeback (write port), and its ports are a superset of the CPU's existing register file ports.

---
 rtl/regfile_scoreboard_pkg.sv | 10 +
 rtl/regfile_scoreboard_bits.sv | 35 +++
 rtl/regfile_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared CPU datapath types and defaults for the register file and its
// busy scoreboard.
package regfile_scoreboard_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int ZERO_IDX   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy bits: set (reserve) wins over clear (writeback) on the
// same index; register 0 can be pinned idle.
module regfile_scoreboard_bits
  import regfile_scoreboard_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  output logic [DEPTH-1:0]  busy_o
);

  logic [DEPTH-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    if (ZERO_REG) busy_d[ZERO_IDX]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with write-to-read bypass, optional
// hardwired-zero register 0 and a busy scoreboard for multi-cycle producers.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1,
  localparam int DEPTH   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writeadd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveadd,
  input  logic [ADDR_W-1:0] readadd1,
  input  logic [ADDR_W-1:0] readadd2,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic              readbusy1,
  output logic              readbusy2,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_ok, rsv_ok;

  // Writes and reserves aimed at a hardwired-zero register are dropped.
  assign wr_ok  = regwrite && !(ZERO_REG && writeadd == ZADDR);
  assign rsv_ok = reserve  && !(ZERO_REG && reserveadd == ZADDR);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[writeadd] = writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard_bits #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_bits (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (rsv_ok),
    .set_idx_i (reserveadd),
    .clr_en_i  (wr_ok),
    .clr_idx_i (writeadd),
    .busy_o    (busy_vec)
  );

  // Read ports: zero register first, then same-cycle bypass, then storage.
  always_comb begin
    readdata1 = mem_q[readadd1];
    readbusy1 = busy_vec[readadd1];
    if (ZERO_REG && readadd1 == ZADDR) begin
      readdata1 = '0;
      readbusy1 = 1'b0;
    end else if (BYPASS && regwrite && writeadd == readadd1) begin
      readdata1 = writedata;
      readbusy1 = 1'b0;
    end
  end

  always_comb begin
    readdata2 = mem_q[readadd2];
    readbusy2 = busy_vec[readadd2];
    if (ZERO_REG && readadd2 == ZADDR) begin
      readdata2 = '0;
      readbusy2 = 1'b0;
    end else if (BYPASS && regwrite && writeadd == readadd2) begin
      readdata2 = writedata;
      readbusy2 = 1'b0;
    end
  end

endmodule
